seq_divider: RTL
================

# seq_divider

Sequential unsigned fixed-point divider on the far side of the motion-controller divider handshake. It accepts `divident`/`divisor` with a one-cycle `start_divide` strobe and returns `quotinent = (divident << 32) / divisor` as a 64-bit value: 32 integer bits and 32 fractional bits. The trajectory/DDA block uses it to turn distance and time into per-clock velocity. One divider serves one requester; arbitration is outside this block.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `divident` in 32: unsigned numerator; sampled only on the accepting edge.
- `divisor` in 32: unsigned denominator; sampled only on the accepting edge.
- `start_divide` in 1: request strobe; accepted only when idle.
- `quotinent` out 64: result, {integer[63:32], fraction[31:0]}.
- `divide_done` out 1: level; high while `quotinent` holds a valid result and the block is idle.
- `busy` out 1: high while an operation is in progress.

## Operation
- States: IDLE and RUN.
- IDLE:
  - On an edge with `start_divide=1`, latch numerator N={divident,32'b0} (64b) and divisor D (32b).
  - On that same edge: clear remainder R (33b), load iteration counter with 64, set `busy=1`, clear `divide_done`, go to RUN.
  - `quotinent` keeps its old value until completion.
- RUN, restoring division one bit per edge, MSB of N first:
  - R' = {R[31:0], N msb}.
  - If R' >= {1'b0,D}: R = R' − D and shift quotient bit 1 into Q; else R = R' and shift in 0.
  - Shift N left by 1; decrement the counter.
  - On the edge that consumes the last bit: load `quotinent` from the final Q, set `divide_done=1`, clear `busy`, return to IDLE.
- Arithmetic:
  - Unsigned only. Sign handling belongs to the requester.
  - The result always fits in 64 bits, so no overflow is possible.
  - Remainder is discarded (truncating division).
- Divisor zero: runs the normal latency, then produces `quotinent = 64'hFFFF_FFFF_FFFF_FFFF` with `divide_done=1` (saturated result). The restoring algorithm yields this naturally; it is required behaviour.
- `start_divide` during RUN: ignored; no queueing, no restart.
- `start_divide` on the completion edge: ignored, because the block is still RUN on that edge. Accepted from the next edge onward.
- `divide_done` stays high until the next accepted start or reset. Requesters must issue `start_divide` and not test `divide_done` on that same cycle.
- Reset, including mid-operation: abort the operation and go to IDLE.

## Timing
- Reset values: `quotinent=0`, `divide_done=0`, `busy=0`, state IDLE, counter 0.
- Start accepted at edge E:
  - `busy=1` and `divide_done=0` are visible after E.
  - `quotinent` valid and `divide_done=1` after edge E+64 (radix-2).
  - `busy=0` after edge E+64.
- Minimum spacing between accepted starts: 65 edges (E and E+65).
- A requester that registers `start_divide` and tests `divide_done` two cycles later always sees the new low level, never a stale high.

## Configuration
- `SEQ_DIVIDER_RADIX4_EN`:
  - Defined: two restoring steps chained combinationally per edge; counter loads 32.
  - Defined, timing: done after edge E+32; minimum start spacing 33 edges.
  - Defined, results: bit-identical to radix-2, including divisor zero.
  - Undefined: radix-2, latency 64.
  - Either way, the handshake, reset behaviour and port list are unchanged.

## Test plan
- divident=1000, divisor=4000, start at E → after E+64, `quotinent=64'h0000_0000_4000_0000`, `divide_done=1`, `busy=0`.
- divident=5, divisor=1 → `64'h0000_0005_0000_0000`. divident=32'hFFFF_FFFF, divisor=1 → `64'hFFFF_FFFF_0000_0000`.
- divisor=0, divident=7 → after the normal latency, `quotinent=64'hFFFF_FFFF_FFFF_FFFF`, `divide_done=1`.
- Start divident=3/divisor=2, then assert start with divident=9/divisor=1 at E+10 and at E+64 → result `64'h0000_0001_8000_0000`. Neither re-start is accepted. Start at E+65 is accepted and yields 9<<32.
- Assert reset at E+20 → next cycle `busy=0`, `divide_done=0`, `quotinent=0`. A fresh start completes correctly.
- Random sweep of 10k pairs (D≠0) against reference model (N<<32)/D. Repeat with `SEQ_DIVIDER_RADIX4_EN`, checking 32-edge latency.

Source files
------------

// File: rtl/seq_divider_if.sv
// Requester <-> divider handshake bundle for seq_divider.
// The master modport is the requester (trajectory/DDA side); the slave
// modport is the divider itself.
interface seq_divider_if;
  logic [31:0] divident;
  logic [31:0] divisor;
  logic        start_divide;
  logic [63:0] quotinent;
  logic        divide_done;
  logic        busy;

  modport master (
    output divident,
    output divisor,
    output start_divide,
    input  quotinent,
    input  divide_done,
    input  busy
  );

  modport slave (
    input  divident,
    input  divisor,
    input  start_divide,
    output quotinent,
    output divide_done,
    output busy
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned fixed-point divider.
//   quotinent = (divident << 32) / divisor, 32.32 format, truncating.
// A restoring divider that consumes the 64-bit numerator MSB first.
// Divisor zero falls out of the algorithm as an all-ones (saturated) result.
//
// Build option:
//   SEQ_DIVIDER_RADIX4_EN  - two restoring steps per clock, latency 32 edges.
//   (undefined)            - one restoring step per clock, latency 64 edges.
// Results, handshake and reset behaviour are identical in both builds.
module seq_divider (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave div_if
);

`ifdef SEQ_DIVIDER_RADIX4_EN
  localparam int unsigned BITS_PER_EDGE = 2;
`else
  localparam int unsigned BITS_PER_EDGE = 1;
`endif
  localparam logic [6:0] ITERATIONS = 7'(64 / BITS_PER_EDGE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Result of one restoring step: updated remainder plus the quotient bit.
  typedef struct packed {
    logic [32:0] rem;
    logic        qbit;
  } step_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [63:0] r_num;    // numerator, shifted left as bits are consumed
  logic [31:0] r_den;    // latched divisor
  logic [32:0] r_rem;    // partial remainder; one spare bit for the trial
  logic [63:0] r_q;      // quotient being assembled
  logic [6:0]  r_cnt;    // steps remaining (edges, not bits)
  logic [63:0] r_quot;   // last completed result, held between operations
  logic        r_done;

  logic        w_accept;
  logic        w_last;
  logic [32:0] w_rem_next;
  logic [63:0] w_num_next;
  logic [63:0] w_q_next;
  step_t       w_step_hi;
`ifdef SEQ_DIVIDER_RADIX4_EN
  step_t       w_step_lo;
`endif

  // One restoring step. R never exceeds D-1 < 2^32, so R[32] is always
  // zero and dropping it when shifting loses nothing. With D == 0 the
  // trial always succeeds, giving a quotient bit of 1 every step.
  function automatic step_t restore_step(input logic [32:0] rem,
                                         input logic        nbit,
                                         input logic [31:0] den);
    logic [32:0] trial;
    step_t       res;
    trial = {rem[31:0], nbit};
    if (trial >= {1'b0, den}) begin
      res.rem  = trial - {1'b0, den};
      res.qbit = 1'b1;
    end else begin
      res.rem  = trial;
      res.qbit = 1'b0;
    end
    return res;
  endfunction

  // Datapath for one clock of RUN: one or two chained restoring steps.
  always_comb begin
    w_step_hi  = restore_step(r_rem, r_num[63], r_den);
`ifdef SEQ_DIVIDER_RADIX4_EN
    w_step_lo  = restore_step(w_step_hi.rem, r_num[62], r_den);
    w_rem_next = w_step_lo.rem;
    w_num_next = {r_num[61:0], 2'b00};
    w_q_next   = {r_q[61:0], w_step_hi.qbit, w_step_lo.qbit};
`else
    w_rem_next = w_step_hi.rem;
    w_num_next = {r_num[62:0], 1'b0};
    w_q_next   = {r_q[62:0], w_step_hi.qbit};
`endif
  end

  // Next-state logic: accept a start only when idle, leave RUN on the last step.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (div_if.start_divide) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A start on this edge is ignored: the block is still RUN here.
        if (r_cnt == 7'd1) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand latching, iteration and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_done <= 1'b0;
    end else if (w_accept) begin
      // r_quot is left alone: the previous result stays visible until completion.
      r_num  <= {div_if.divident, 32'h0000_0000};
      r_den  <= div_if.divisor;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= ITERATIONS;
      r_done <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_num <= w_num_next;
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - 7'd1;
      if (w_last) begin
        r_quot <= w_q_next;
        r_done <= 1'b1;
      end
    end
  end

  assign div_if.quotinent   = r_quot;
  assign div_if.divide_done = r_done;
  assign div_if.busy        = (r_state == ST_RUN);

endmodule
